// File: rtl/spi_tx_feeder.sv
// spi_tx_feeder: upstream feeder for the SPI top.
// Takes parallel words over a valid/ready port, buffers them in a small FIFO and shifts them
// out MSB-first onto cs_in (active-low chip select) and data_in. Each serial bit is held for
// BIT_PERIOD clocks. Words already queued when a word finishes go out in the same frame.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   s_valid    - upstream word valid
//   s_data     - upstream word
//   s_ready    - FIFO not full (from registered count)
//   cs_in      - chip select to SPI top, active-low (registered)
//   data_in    - serial data to SPI top (registered)
//   busy       - FSM not idle
//   fifo_count - number of stored words
//   frame_done - one-clock pulse in the cycle cs_in returns high
//
// Optional feature: define SPI_TX_PARITY_EN to append one even-parity bit period after the
// DATA_W data bits of every word.
//
// Output timing: cs_in, data_in and frame_done are registered from the current FSM state, so
// they trail the state by one clock. A word pushed at edge N therefore drops cs_in at edge N+2,
// and every state duration maps one-to-one onto the output waveform.

module spi_tx_feeder #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BIT_PERIOD = 9,
  parameter int unsigned IDLE_GAP   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  input  logic [DATA_W-1:0]             s_data,
  output logic                          s_ready,
  output logic                          cs_in,
  output logic                          data_in,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_done
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
`ifdef SPI_TX_PARITY_EN
  localparam int unsigned NBits = DATA_W + 1;
`else
  localparam int unsigned NBits = DATA_W;
`endif
  localparam int unsigned BitW = (NBits > 1) ? $clog2(NBits) : 1;
  localparam int unsigned PerW = $clog2(BIT_PERIOD);
  localparam int unsigned GapW = $clog2(IDLE_GAP + 1);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StGap
  } state_e;

  // ---------------------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  // s_ready depends only on the registered count, so a pop in the same cycle never frees a
  // slot while full.
  assign s_ready = (count_q != CntW'(FIFO_DEPTH));
  assign push    = s_valid && s_ready;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    // Push and pop together leave the count unchanged; no push happens while full and no
    // pop while empty, so the count can neither overflow nor underflow.
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  assign fifo_count = count_q;

  // ---------------------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [PerW-1:0]   period_q, period_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              cs_q, cs_d;
  logic              data_q, data_d;
  logic              done_q, done_d;
  logic              period_end;
`ifdef SPI_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign period_end = (period_q == PerW'(BIT_PERIOD - 1));

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    period_d = period_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    pop      = 1'b0;
`ifdef SPI_TX_PARITY_EN
    par_d    = par_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop      = 1'b1;
          shreg_d  = head;
          period_d = '0;
          bit_d    = '0;
`ifdef SPI_TX_PARITY_EN
          par_d    = ^head;
`endif
          state_d  = StSetup;
        end
      end

      // First bit window of a frame: the MSB is presented with cs_in low so the master gets
      // its setup time; this window counts as the MSB's hold period.
      StSetup: begin
        if (period_end) begin
          period_d = '0;
          bit_d    = BitW'(1);
          shreg_d  = shreg_q << 1;
          state_d  = StShift;
        end else begin
          period_d = period_q + PerW'(1);
        end
      end

      StShift: begin
        if (period_end) begin
          period_d = '0;
          if (bit_q == BitW'(NBits - 1)) begin
            if (count_q != '0) begin
              // Next word continues the frame with no gap; its MSB goes out immediately.
              pop     = 1'b1;
              shreg_d = head;
              bit_d   = '0;
`ifdef SPI_TX_PARITY_EN
              par_d   = ^head;
`endif
            end else begin
              gap_d   = '0;
              state_d = StGap;
            end
          end else begin
            bit_d   = bit_q + BitW'(1);
            shreg_d = shreg_q << 1;
          end
        end else begin
          period_d = period_q + PerW'(1);
        end
      end

      StGap: begin
        if (gap_q == GapW'(IDLE_GAP - 1)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered outputs, decoded from the current state.
  always_comb begin
    cs_d   = 1'b1;
    data_d = 1'b0;
    done_d = 1'b0;
    unique case (state_q)
      StSetup, StShift: begin
        cs_d   = 1'b0;
        data_d = shreg_q[DATA_W-1];
`ifdef SPI_TX_PARITY_EN
        if (bit_q == BitW'(DATA_W)) begin
          data_d = par_q;
        end
`endif
      end
      StGap: begin
        done_d = (gap_q == '0);
      end
      default: begin
        cs_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      period_q <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      cs_q     <= 1'b1;
      data_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SPI_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      period_q <= period_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      cs_q     <= cs_d;
      data_q   <= data_d;
      done_q   <= done_d;
`ifdef SPI_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign cs_in      = cs_q;
  assign data_in    = data_q;
  assign frame_done = done_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Testbench for spi_tx_feeder: directed and random pushes, with a waveform decoder that
// rebuilds words from cs_in/data_in and compares them to the queue of accepted words.

module tb_spi_tx_feeder;

  localparam int DW  = 8;
  localparam int FD  = 4;
  localparam int BP  = 9;
  localparam int GAP = 2;
`ifdef SPI_TX_PARITY_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          cs_in;
  logic          data_in;
  logic          busy;
  logic [2:0]    fifo_count;
  logic          frame_done;

  spi_tx_feeder #(
    .DATA_W    (DW),
    .FIFO_DEPTH(FD),
    .BIT_PERIOD(BP),
    .IDLE_GAP  (GAP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .cs_in     (cs_in),
    .data_in   (data_in),
    .busy      (busy),
    .fifo_count(fifo_count),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];   // words accepted by the FIFO, in order
  logic [DW-1:0] got_q[$];   // words decoded from the serial waveform
  int            got_len[$]; // cs_in-low length of each completed frame
  logic          got_par[$]; // decoded parity bits
  logic          samp[$];
  logic          prev_cs = 1'b1;
  bit            mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decode one finished frame: NB bit windows of BP clocks per word, MSB first.
  task automatic decode_frame();
    int nwords;
    int unstable;
    got_len.push_back(samp.size());
    check("frame_len_multiple", 32'(samp.size() % (NB * BP)), 32'd0);
    nwords = samp.size() / (NB * BP);
    unstable = 0;
    for (int w = 0; w < nwords; w++) begin
      logic [DW-1:0] v;
      v = '0;
      for (int k = 0; k < NB; k++) begin
        logic b;
        b = samp[(w * NB + k) * BP];
        for (int j = 1; j < BP; j++) begin
          if (samp[(w * NB + k) * BP + j] !== b) unstable++;
        end
        if (k < DW) begin
          v = {v[DW-2:0], b};
        end else begin
          got_par.push_back(b);
          check("parity_bit", 32'(b), 32'(^v));
        end
      end
      got_q.push_back(v);
    end
    check("bit_stable", 32'(unstable), 32'd0);
    samp.delete();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("frame_done_on_cs_rise", 32'(frame_done), 32'(prev_cs == 1'b0 && cs_in == 1'b1));
      if (cs_in == 1'b0) begin
        samp.push_back(data_in);
      end else begin
        check("data_low_when_idle", 32'(data_in), 32'd0);
        if (prev_cs == 1'b0) decode_frame();
      end
      prev_cs = cs_in;
    end
  end

  // Offer one word; returns the number of cycles spent waiting for s_ready.
  task automatic push(input logic [DW-1:0] b, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    s_valid = 1'b1;
    s_data  = b;
    for (int i = 0; i < 1000; i++) begin
      check("ready_is_not_full", 32'(s_ready), 32'(fifo_count != 3'(FD)));
      if (s_ready) begin
        step();
        exp_q.push_back(b);
        ok = 1'b1;
        break;
      end
      waited++;
      step();
    end
    check("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!busy && fifo_count == 3'd0 && cs_in && !s_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("reached_idle", 32'(ok), 32'd1);
    repeat (3) step();
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_word_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int w;
    int total;
    int cs_low_seen;
    int done_seen;
    bit found;

    // 1: reset held for three clocks
    reset = 1'b1;
    repeat (3) step();
    check("rst_cs", 32'(cs_in), 32'd1);
    check("rst_data", 32'(data_in), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd1);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    step();
    prev_cs = 1'b1;
    mon_en  = 1'b1;

    // 2: single word, latency and frame length
    s_valid = 1'b1;
    s_data  = 8'hB6;
    step();
    exp_q.push_back(8'hB6);
    s_valid = 1'b0;
    check("lat_edge_n", 32'(cs_in), 32'd1);
    check("lat_count", 32'(fifo_count), 32'd1);
    step();
    check("lat_edge_n1", 32'(cs_in), 32'd1);
    step();
    check("lat_edge_n2", 32'(cs_in), 32'd0);
    check("first_bit_msb", 32'(data_in), 32'd1);
    wait_idle();
    compare_stream("single");
    check("single_frames", 32'(got_len.size()), 32'd1);
    if (got_len.size() > 0) check("single_len", 32'(got_len[0]), 32'(NB * BP));
    got_len.delete();
    got_par.delete();

    // 3: two words back to back share one frame
    push(8'hA5, w);
    push(8'h3C, w);
    s_valid = 1'b0;
    wait_idle();
    compare_stream("pair");
    check("pair_frames", 32'(got_len.size()), 32'd1);
    if (got_len.size() > 0) check("pair_len", 32'(got_len[0]), 32'(2 * NB * BP));
    got_len.delete();
    got_par.delete();

    // 4: fill the FIFO with s_valid held; the last offer must stall until a slot frees
    for (int i = 0; i < 5; i++) push(8'(8'h11 * (i + 1)), w);
    check("fifo_full_after_five", 32'(s_ready), 32'd0);
    check("fifo_count_full", 32'(fifo_count), 32'(FD));
    push(8'hC3, w);
    check("sixth_stalled", 32'(w > 0), 32'd1);
    s_valid = 1'b0;
    wait_idle();
    compare_stream("burst");
    check("burst_frames", 32'(got_len.size()), 32'd1);
    if (got_len.size() > 0) check("burst_len", 32'(got_len[0]), 32'(6 * NB * BP));
    got_len.delete();
    got_par.delete();

    // 5: reset in the middle of a frame
    push(8'hFF, w);
    push(8'h01, w);
    push(8'h02, w);
    s_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!cs_in) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("midframe_started", 32'(found), 32'd1);
    repeat (3 * BP + 4) step();
    mon_en = 1'b0;
    reset = 1'b1;
    step();
    check("midrst_cs", 32'(cs_in), 32'd1);
    check("midrst_data", 32'(data_in), 32'd0);
    check("midrst_count", 32'(fifo_count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    cs_low_seen = 0;
    done_seen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (!cs_in) cs_low_seen++;
      if (frame_done) done_seen++;
    end
    check("midrst_no_more_bits", 32'(cs_low_seen), 32'd0);
    check("midrst_no_frame_done", 32'(done_seen), 32'd0);
    exp_q.delete();
    got_q.delete();
    got_len.delete();
    got_par.delete();
    samp.delete();
    prev_cs = 1'b1;
    mon_en  = 1'b1;

`ifdef SPI_TX_PARITY_EN
    // 6: parity bit follows the data bits
    push(8'h07, w);
    s_valid = 1'b0;
    wait_idle();
    push(8'h03, w);
    s_valid = 1'b0;
    wait_idle();
    compare_stream("parity");
    check("parity_count", 32'(got_par.size()), 32'd2);
    if (got_par.size() == 2) begin
      check("parity_07", 32'(got_par[0]), 32'd1);
      check("parity_03", 32'(got_par[1]), 32'd0);
    end
    got_len.delete();
    got_par.delete();
`endif

    // Random words with random gaps
    for (int i = 0; i < 16; i++) begin
      push(8'($urandom), w);
      s_valid = 1'b0;
      repeat ($urandom_range(0, 90)) step();
    end
    wait_idle();
    compare_stream("random");
    total = 0;
    foreach (got_len[i]) total += got_len[i];
    check("random_total_len", 32'(total), 32'(16 * NB * BP));

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
